// File: rtl/ld_to_affine.sv
// Lopez-Dahab projective (X,Y,Z) to affine (X/Z, Y/Z^2) over GF(2^4), poly x^4+x+1.
// Optional on-curve check enabled by defining LD_AFFINE_CURVE_CHECK_EN (adds one cycle).
module ld_to_affine #(
    parameter logic [3:0] A_CONST = 4'b0100,
    parameter logic [3:0] B_CONST = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] X_in,
    input  logic [3:0] Y_in,
    input  logic [3:0] Z_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] x_out,
    output logic [3:0] y_out,
    output logic       out_inf,
    output logic       out_on_curve
);

    typedef enum logic [2:0] {
        StIdle, StInv0, StInv1, StInv2, StMulX, StMulY, StCheck, StDone
    } state_e;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    // Squaring is linear: x^4 -> x+1, x^6 -> x^3+x^2.
    function automatic logic [3:0] gf_sqr(input logic [3:0] a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

    state_e     state_q;
    logic [3:0] x_q, y_q, r_q, s_q;
    logic [3:0] x_out_q, y_out_q;
    logic       inf_q, on_curve_q, valid_q;

    logic [3:0] mul_a, mul_b, mul_p, sq_in, sq_p;

    always_comb begin
        mul_a = r_q;
        mul_b = s_q;
        sq_in = s_q;
        case (state_q)
            StIdle: sq_in = Z_in;
            StMulX: begin
                mul_a = x_q;
                mul_b = r_q;
                sq_in = r_q;
            end
            StMulY: begin
                mul_a = y_q;
                mul_b = s_q;
            end
            StCheck: begin
                mul_a = x_out_q;
                mul_b = y_out_q;
                sq_in = y_out_q;
            end
            default: ;
        endcase
    end

    assign mul_p = gf_mul(mul_a, mul_b);
    assign sq_p  = gf_sqr(sq_in);

`ifdef LD_AFFINE_CURVE_CHECK_EN
    logic [3:0] lhs, rhs;
    // y^2 + x*y  vs  x^2*(x+a) + b
    assign lhs = sq_p ^ mul_p;
    assign rhs = gf_mul(gf_sqr(x_out_q), x_out_q ^ A_CONST) ^ B_CONST;
`else
    logic unused_cfg;
    assign unused_cfg = ^{A_CONST, B_CONST};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= 4'h0;
            y_q        <= 4'h0;
            r_q        <= 4'h0;
            s_q        <= 4'h0;
            x_out_q    <= 4'h0;
            y_out_q    <= 4'h0;
            inf_q      <= 1'b0;
            on_curve_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
`ifndef LD_AFFINE_CURVE_CHECK_EN
            on_curve_q <= 1'b1;
`endif
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q     <= X_in;
                        y_q     <= Y_in;
                        s_q     <= sq_p;
                        inf_q   <= (Z_in == 4'h0);
                        state_q <= StInv0;
                    end
                end
                StInv0: begin
                    r_q     <= s_q;
                    s_q     <= sq_p;
                    state_q <= StInv1;
                end
                StInv1: begin
                    r_q     <= mul_p;
                    s_q     <= sq_p;
                    state_q <= StInv2;
                end
                StInv2: begin
                    r_q     <= mul_p;
                    state_q <= StMulX;
                end
                StMulX: begin
                    x_out_q <= mul_p;
                    s_q     <= sq_p;
                    state_q <= StMulY;
                end
                StMulY: begin
                    y_out_q <= mul_p;
`ifdef LD_AFFINE_CURVE_CHECK_EN
                    state_q <= StCheck;
`else
                    valid_q <= 1'b1;
                    state_q <= StDone;
`endif
                end
`ifdef LD_AFFINE_CURVE_CHECK_EN
                StCheck: begin
                    on_curve_q <= !inf_q && (lhs == rhs);
                    valid_q    <= 1'b1;
                    state_q    <= StDone;
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready     = rst_n && (state_q == StIdle);
    assign out_valid    = valid_q;
    assign x_out        = x_out_q;
    assign y_out        = y_out_q;
    assign out_inf      = inf_q;
    assign out_on_curve = on_curve_q;

endmodule

// File: tb/tb_ld_to_affine.sv
// Directed bench for ld_to_affine: identity, scaling, infinity, curve check,
// backpressure, busy-input rejection and reset during conversion.
module tb_ld_to_affine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] X_in, Y_in, Z_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] x_out, y_out;
    logic       out_inf;
    logic       out_on_curve;

    int checks = 0;
    int errors = 0;

`ifdef LD_AFFINE_CURVE_CHECK_EN
    localparam int Lat     = 6;
    localparam bit CheckEn = 1'b1;
`else
    localparam int Lat     = 5;
    localparam bit CheckEn = 1'b0;
`endif

    ld_to_affine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .X_in         (X_in),
        .Y_in         (Y_in),
        .Z_in         (Z_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .x_out        (x_out),
        .y_out        (y_out),
        .out_inf      (out_inf),
        .out_on_curve (out_on_curve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic convert(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input logic [3:0] z, input logic [3:0] ex, input logic [3:0] ey,
                           input logic einf, input logic eoc_check, input int hold,
                           input bit noise);
        int n;
        logic eoc;
        eoc = CheckEn ? eoc_check : 1'b1;
        @(negedge clk);
        chk({tag, " ready"}, 16'(in_ready), 16'h1);
        X_in     = x;
        Y_in     = y;
        Z_in     = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (noise) begin
            X_in = 4'hF;
            Y_in = 4'hE;
            Z_in = 4'h3;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 16'(n), 16'(Lat));
        chk({tag, " x"}, 16'(x_out), 16'(ex));
        chk({tag, " y"}, 16'(y_out), 16'(ey));
        chk({tag, " inf"}, 16'(out_inf), 16'(einf));
        chk({tag, " on_curve"}, 16'(out_on_curve), 16'(eoc));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold"}, {4'h0, out_valid, in_ready, out_inf, out_on_curve, x_out, y_out},
                {4'h0, 1'b1, 1'b0, einf, eoc, ex, ey});
        end
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, " ready in handshake"}, 16'(in_ready), 16'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " valid drop"}, 16'(out_valid), 16'h0);
        chk({tag, " ready after"}, 16'(in_ready), 16'h1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X_in      = 4'h0;
        Y_in      = 4'h0;
        Z_in      = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {8'h0, in_ready, out_valid, out_inf, out_on_curve, x_out},
            16'h0);
        chk("reset y", 16'(y_out), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after release", 16'(in_ready), 16'h1);
        chk("on_curve after release", 16'(out_on_curve), CheckEn ? 16'h0 : 16'h1);

        convert("identity", 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 0, 1'b0);
        convert("scaling", 4'h2, 4'h4, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0, 0, 1'b0);
        convert("infinity", 4'h7, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0);
        convert("on_curve", 4'h1, 4'h8, 4'h1, 4'h1, 4'h8, 1'b0, 1'b1, 0, 1'b1);
        convert("z3", 4'h3, 4'h3, 4'h3, 4'h1, 4'hE, 1'b0, 1'b0, 0, 1'b0);
        convert("z1 plain", 4'h5, 4'h6, 4'h1, 4'h5, 4'h6, 1'b0, 1'b0, 0, 1'b1);
        convert("backpressure", 4'h2, 4'h4, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0, 10, 1'b0);

        // Abort a conversion while it sits in INV1.
        @(negedge clk);
        X_in     = 4'h7;
        Y_in     = 4'h3;
        Z_in     = 4'h5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset flags", {12'h0, out_valid, in_ready, out_inf, out_on_curve}, 16'h0);
        chk("midreset xy", {8'h0, x_out, y_out}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no result after reset", 16'(out_valid), 16'h0);
        end
        convert("post reset", 4'h2, 4'h4, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
